// File: rtl/slc3_pkg.sv
// Shared types and constants for the reduced SLC-3 test top: opcodes, FSM states,
// the I/O address, the boot program image and the seven-segment decoder.
package slc3_pkg;

  localparam int          WORD_W   = 16;
  localparam int          NUM_REGS = 8;
  localparam logic [15:0] IO_ADDR  = 16'hFFFF;
  localparam logic [7:0]  BOOT_LO  = 8'h14;
  localparam logic [7:0]  BOOT_HI  = 8'h23;

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000,
    OP_ADD = 4'b0001,
    OP_AND = 4'b0101,
    OP_LDR = 4'b0110,
    OP_STR = 4'b0111,
    OP_NOT = 4'b1001,
    OP_JMP = 4'b1100,
    OP_PSE = 4'b1101
  } opcode_e;

  typedef enum logic [3:0] {
    S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_EXEC, S_MEM1, S_MEM2, S_PAUSE_LO, S_PAUSE_HI
  } state_e;

  function automatic logic [6:0] sevenSeg(input logic [3:0] nibble);
    case (nibble)
      4'h0: sevenSeg = 7'b1000000;
      4'h1: sevenSeg = 7'b1111001;
      4'h2: sevenSeg = 7'b0100100;
      4'h3: sevenSeg = 7'b0110000;
      4'h4: sevenSeg = 7'b0011001;
      4'h5: sevenSeg = 7'b0010010;
      4'h6: sevenSeg = 7'b0000010;
      4'h7: sevenSeg = 7'b1111000;
      4'h8: sevenSeg = 7'b0000000;
      4'h9: sevenSeg = 7'b0010000;
      4'hA: sevenSeg = 7'b0001000;
      4'hB: sevenSeg = 7'b0000011;
      4'hC: sevenSeg = 7'b1000110;
      4'hD: sevenSeg = 7'b0100001;
      4'hE: sevenSeg = 7'b0000110;
      default: sevenSeg = 7'b0001110;
    endcase
  endfunction

  // XOR demo: read two switch values at pauses, display their XOR, loop forever
  function automatic logic [15:0] bootWord(input logic [7:0] addr);
    case (addr)
      8'h14: bootWord = 16'h5020;
      8'h15: bootWord = 16'h103F;
      8'h16: bootWord = 16'hD001;
      8'h17: bootWord = 16'h6200;
      8'h18: bootWord = 16'hD002;
      8'h19: bootWord = 16'h6400;
      8'h1A: bootWord = 16'h967F;
      8'h1B: bootWord = 16'h56C2;
      8'h1C: bootWord = 16'h98BF;
      8'h1D: bootWord = 16'h5901;
      8'h1E: bootWord = 16'h96FF;
      8'h1F: bootWord = 16'h993F;
      8'h20: bootWord = 16'h56C4;
      8'h21: bootWord = 16'h96FF;
      8'h22: bootWord = 16'h7600;
      8'h23: bootWord = 16'h0FF2;
      default: bootWord = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/slc3_regfile.sv
// General-purpose register file R0-R7: two combinational read ports, one write port,
// cleared by asynchronous reset.
module slc3_regfile
  import slc3_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [2:0]        i_wAddr,
  input  logic [WORD_W-1:0] i_wData,
  input  logic [2:0]        i_rAddrA,
  input  logic [2:0]        i_rAddrB,
  output logic [WORD_W-1:0] o_rDataA,
  output logic [WORD_W-1:0] o_rDataB
);

  logic [WORD_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_wAddr] <= i_wData;
    end
  end

  assign o_rDataA = r_regs[i_rAddrA];
  assign o_rDataB = r_regs[i_rAddrB];

endmodule

// File: rtl/slc3_xor_top.sv
// Reduced SLC-3 CPU test top with inline FSM, ALU and RAM; I/O mapped at IO_ADDR.
// Define SLC3_HEXPC_EN to show the PC on the hex digits instead of the HEX register.
module slc3_xor_top
  import slc3_pkg::*;
#(
  parameter int MEM_WORDS = 256
)
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [9:0] SW,
  output logic [9:0] LED,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  localparam int AW = $clog2(MEM_WORDS);

  state_e      r_state, w_nextState;
  logic [15:0] r_pc, r_ir, r_mar, r_mdr, r_hex;
  logic [2:0]  r_nzp;
  logic [9:0]  r_led;
  logic [1:0]  r_runSync, r_contSync;
  logic [15:0] r_ram [MEM_WORDS];

  opcode_e     w_op;
  logic        w_runN, w_contN, w_isIo, w_brTaken, w_bootHit;
  logic        w_regWe, w_ramWe, w_hexWe;
  logic [AW-1:0] w_ramIdx;
  logic [15:0] w_sext5, w_sext6, w_sext9, w_rdA, w_rdB, w_sr2;
  logic [15:0] w_aluOut, w_regWData, w_memRd, w_disp;
  logic [2:0]  w_rAddrB;

  assign w_op      = opcode_e'(r_ir[15:12]);
  assign w_runN    = r_runSync[1];
  assign w_contN   = r_contSync[1];
  assign w_sext5   = {{11{r_ir[4]}}, r_ir[4:0]};
  assign w_sext6   = {{10{r_ir[5]}}, r_ir[5:0]};
  assign w_sext9   = {{7{r_ir[8]}}, r_ir[8:0]};
  assign w_isIo    = (r_mar == IO_ADDR);
  assign w_brTaken = |(r_ir[11:9] & r_nzp);
  assign w_ramIdx  = r_mar[AW-1:0];
  assign w_rAddrB  = (w_op == OP_STR) ? r_ir[11:9] : r_ir[2:0];
  assign w_sr2     = r_ir[5] ? w_sext5 : w_rdB;

  // Boot program is a read-only overlay; everything else reads the RAM array
  assign w_bootHit = (16'(w_ramIdx) >= 16'(BOOT_LO)) && (16'(w_ramIdx) <= 16'(BOOT_HI));
  assign w_memRd   = w_bootHit ? bootWord(8'(w_ramIdx)) : r_ram[w_ramIdx];

  always_comb begin
    case (w_op)
      OP_ADD:  w_aluOut = w_rdA + w_sr2;
      OP_AND:  w_aluOut = w_rdA & w_sr2;
      default: w_aluOut = ~w_rdA;
    endcase
  end

  slc3_regfile u_regfile (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_we     (w_regWe),
    .i_wAddr  (r_ir[11:9]),
    .i_wData  (w_regWData),
    .i_rAddrA (r_ir[8:6]),
    .i_rAddrB (w_rAddrB),
    .o_rDataA (w_rdA),
    .o_rDataB (w_rdB)
  );

  // Buttons idle high, so the synchronizers reset to the released level
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_runSync  <= 2'b11;
      r_contSync <= 2'b11;
    end else begin
      r_runSync  <= {r_runSync[0], Run};
      r_contSync <= {r_contSync[0], Continue};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_HALTED;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_HALTED:   if (!w_runN) w_nextState = S_FETCH1;
      S_FETCH1:   w_nextState = S_FETCH2;
      S_FETCH2:   w_nextState = S_FETCH3;
      S_FETCH3:   w_nextState = S_DECODE;
      S_DECODE:   w_nextState = S_EXEC;
      S_EXEC: begin
        case (w_op)
          OP_LDR, OP_STR: w_nextState = S_MEM1;
          OP_PSE:         w_nextState = S_PAUSE_LO;
          default:        w_nextState = S_FETCH1;
        endcase
      end
      S_MEM1:     w_nextState = (w_op == OP_LDR) ? S_MEM2 : S_FETCH1;
      S_MEM2:     w_nextState = S_FETCH1;
      S_PAUSE_LO: if (!w_contN) w_nextState = S_PAUSE_HI;
      S_PAUSE_HI: if (w_contN) w_nextState = S_FETCH1;
      default:    w_nextState = S_HALTED;
    endcase
  end

  always_comb begin
    w_regWe    = 1'b0;
    w_regWData = w_aluOut;
    w_ramWe    = 1'b0;
    w_hexWe    = 1'b0;
    case (r_state)
      S_EXEC: w_regWe = (w_op == OP_ADD) || (w_op == OP_AND) || (w_op == OP_NOT);
      S_MEM1: begin
        if (w_op == OP_STR) begin
          w_hexWe = w_isIo;
          w_ramWe = !w_isIo;
        end
      end
      S_MEM2: begin
        w_regWe    = 1'b1;
        w_regWData = r_mdr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_nzp <= 3'b010;
      r_led <= '0;
      r_hex <= '0;
    end else begin
      case (r_state)
        S_HALTED: if (!w_runN) r_pc <= {6'b0, SW};
        S_FETCH1: begin
          r_mar <= r_pc;
          r_pc  <= r_pc + 16'd1;
        end
        S_FETCH2: r_mdr <= w_memRd;
        S_FETCH3: r_ir  <= r_mdr;
        S_EXEC: begin
          case (w_op)
            OP_BR:  if (w_brTaken) r_pc <= r_pc + w_sext9;
            OP_JMP: r_pc <= w_rdA;
            OP_LDR: r_mar <= w_rdA + w_sext6;
            OP_STR: begin
              r_mar <= w_rdA + w_sext6;
              r_mdr <= w_rdB;
            end
            OP_PSE: r_led <= r_ir[9:0];
            default: ;
          endcase
        end
        S_MEM1: if (w_op == OP_LDR) r_mdr <= w_isIo ? {6'b0, SW} : w_memRd;
        default: ;
      endcase
      if (w_regWe) r_nzp <= {w_regWData[15], w_regWData == 16'h0, !w_regWData[15] && (w_regWData != 16'h0)};
      if (w_hexWe) r_hex <= r_mdr;
    end
  end

  // RAM contents deliberately survive reset
  always_ff @(posedge Clk) begin
    if (w_ramWe) r_ram[w_ramIdx] <= r_mdr;
  end

`ifdef SLC3_HEXPC_EN
  assign w_disp = r_pc;
`else
  assign w_disp = r_hex;
`endif

  assign LED  = r_led;
  assign HEX0 = sevenSeg(w_disp[3:0]);
  assign HEX1 = sevenSeg(w_disp[7:4]);
  assign HEX2 = sevenSeg(w_disp[11:8]);
  assign HEX3 = sevenSeg(w_disp[15:12]);

endmodule

// File: tb/tb_slc3_xor_top.sv
// Self-checking bench for slc3_xor_top: runs the built-in XOR program over a table
// of switch pairs, plus pause-hold and mid-loop reset sequences.
module tb_slc3_xor_top;
  import slc3_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue;
  logic [9:0] SW;
  logic [9:0] LED;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [9:0]  swA;
    logic [9:0]  swB;
    logic [15:0] expHex;
    logic [2:0]  expNzp;
    logic [6:0]  expD0, expD1, expD2, expD3;
  } vec_t;

  vec_t vecs[4];

  slc3_xor_top dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .SW(SW),
    .LED(LED), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] sw);
    SW = sw;
    Continue = 1'b0;
    repeat (6) @(negedge Clk);
    Continue = 1'b1;
  endtask

  task automatic waitPause(input string name);
    bit found = 0;
    for (int k = 0; k < 400; k++) begin
      if (dut.r_state == S_PAUSE_LO) begin
        found = 1;
        break;
      end
      @(negedge Clk);
    end
    if (!found) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: pause not reached within 400 cycles", name);
    end
  endtask

  task automatic checkDigits(input string name, input logic [6:0] d0, input logic [6:0] d1,
                             input logic [6:0] d2, input logic [6:0] d3);
    checkOutput({name, "_hex0"}, {9'b0, HEX0}, {9'b0, d0});
    checkOutput({name, "_hex1"}, {9'b0, HEX1}, {9'b0, d1});
    checkOutput({name, "_hex2"}, {9'b0, HEX2}, {9'b0, d2});
    checkOutput({name, "_hex3"}, {9'b0, HEX3}, {9'b0, d3});
  endtask

  initial begin
    vecs[0] = '{10'h0B6, 10'h32D, 16'h039B, 3'b001, 7'b0000011, 7'b0010000, 7'b0110000, 7'b1000000};
    vecs[1] = '{10'h155, 10'h155, 16'h0000, 3'b010, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    vecs[2] = '{10'h3FF, 10'h000, 16'h03FF, 3'b001, 7'b0001110, 7'b0001110, 7'b0110000, 7'b1000000};
    vecs[3] = '{10'h2AA, 10'h0F0, 16'h025A, 3'b001, 7'b0001000, 7'b0010010, 7'b0100100, 7'b1000000};

    Reset = 1'b1; Run = 1'b1; Continue = 1'b1; SW = 10'h014;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("rst_led", {6'b0, LED}, 16'h0000);
    checkOutput("rst_pc", dut.r_pc, 16'h0000);
    checkOutput("rst_nzp", {13'b0, dut.r_nzp}, 16'h0002);
    checkOutput("rst_state", 16'(dut.r_state), 16'(S_HALTED));
    checkDigits("rst", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);

    // Start: wait for the PC load out of HALTED
    Run = 1'b0;
    for (int k = 0; k < 20 && dut.r_state == S_HALTED; k++) @(negedge Clk);
    checkOutput("run_state", 16'(dut.r_state), 16'(S_FETCH1));
    checkOutput("run_pc", dut.r_pc, 16'h0014);
    Run = 1'b1;

    waitPause("first_pause");
    checkOutput("p1_led", {6'b0, LED}, 16'h0001);
    checkOutput("p1_r0", dut.u_regfile.r_regs[0], 16'hFFFF);
`ifdef SLC3_HEXPC_EN
    checkDigits("p1", 7'b1111000, 7'b1111001, 7'b1000000, 7'b1000000);
`else
    checkDigits("p1", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
`endif

    // Holding at the pause must not advance anything
    repeat (50) @(negedge Clk);
    checkOutput("hold_state", 16'(dut.r_state), 16'(S_PAUSE_LO));
    checkOutput("hold_pc", dut.r_pc, 16'h0017);
    checkOutput("hold_r0", dut.u_regfile.r_regs[0], 16'hFFFF);
    checkOutput("hold_led", {6'b0, LED}, 16'h0001);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].swA);
      waitPause("pause_a");
      checkOutput("a_led", {6'b0, LED}, 16'h0002);
      checkOutput("a_pc", dut.r_pc, 16'h0019);
      checkOutput("a_r1", dut.u_regfile.r_regs[1], {6'b0, vecs[i].swA});
      applyStimulus(vecs[i].swB);
      waitPause("pause_b");
      checkOutput("b_led", {6'b0, LED}, 16'h0001);
      checkOutput("b_r2", dut.u_regfile.r_regs[2], {6'b0, vecs[i].swB});
      checkOutput("b_r3", dut.u_regfile.r_regs[3], vecs[i].expHex);
      checkOutput("b_hexreg", dut.r_hex, vecs[i].expHex);
      checkOutput("b_nzp", {13'b0, dut.r_nzp}, {13'b0, vecs[i].expNzp});
`ifdef SLC3_HEXPC_EN
      checkDigits("b", 7'b1111000, 7'b1111001, 7'b1000000, 7'b1000000);
`else
      checkDigits("b", vecs[i].expD0, vecs[i].expD1, vecs[i].expD2, vecs[i].expD3);
`endif
    end

    // Reset in the middle of the loop clears state before the next edge
    applyStimulus(10'h0F0);
    repeat (12) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    checkOutput("mid_state", 16'(dut.r_state), 16'(S_HALTED));
    checkOutput("mid_pc", dut.r_pc, 16'h0000);
    checkOutput("mid_ir", dut.r_ir, 16'h0000);
    checkOutput("mid_mar", dut.r_mar, 16'h0000);
    checkOutput("mid_mdr", dut.r_mdr, 16'h0000);
    checkOutput("mid_r0", dut.u_regfile.r_regs[0], 16'h0000);
    checkOutput("mid_r1", dut.u_regfile.r_regs[1], 16'h0000);
    checkOutput("mid_r3", dut.u_regfile.r_regs[3], 16'h0000);
    checkOutput("mid_hexreg", dut.r_hex, 16'h0000);
    checkOutput("mid_nzp", {13'b0, dut.r_nzp}, 16'h0002);
    checkOutput("mid_led", {6'b0, LED}, 16'h0000);
    checkDigits("mid", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("post_state", 16'(dut.r_state), 16'(S_HALTED));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
